// File: rtl/alu_pipe_pkg.sv
// Shared types and parameter limits for the pipelined ALU.
// The optional multiplier (OP 15 = MUL) is enabled with the ALU_MULT_EN macro.
package alu_pipe_pkg;

  localparam int ALU_DW_MIN = 4;
  localparam int ALU_DW_MAX = 64;
  localparam int ALU_PS_MIN = 1;
  localparam int ALU_PS_MAX = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_INC  = 4'd2,
    ALU_DEC  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOT  = 4'd7,
    ALU_NAND = 4'd8,
    ALU_NOR  = 4'd9,
    ALU_XNOR = 4'd10,
    ALU_SHL  = 4'd11,
    ALU_SHR  = 4'd12,
    ALU_ROL  = 4'd13,
    ALU_ROR  = 4'd14,
    ALU_PASS = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    MOVI_REG_B = 2'b00,
    MOVI_MEM   = 2'b01,
    MOVI_IMM   = 2'b10,
    MOVI_ILL   = 2'b11
  } alu_movi_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_calc.sv
// Combinational operand-B select, ALU operation and flag generation.
// With ALU_MULT_EN defined, OP 15 multiplies instead of passing B through.
module alu_pipe_calc
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  alu_op_t               op_i,
  input  alu_movi_t             movi_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] reg_b_i,
  input  logic [DATA_WIDTH-1:0] mem_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output alu_flags_t            flags_o
);

  localparam logic [DATA_WIDTH:0] ONE_W = {{DATA_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH-1:0] res;
  logic                  carry;
`ifdef ALU_MULT_EN
  logic [2*DATA_WIDTH-1:0] prod;
  assign prod = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b};
`endif

  always_comb begin
    b = reg_b_i;
    case (movi_i)
      MOVI_MEM: b = mem_i;
      MOVI_IMM: b = imm_i;
      default:  b = reg_b_i;
    endcase
  end

  always_comb begin
    wide  = '0;
    res   = '0;
    carry = 1'b0;
    case (op_i)
      ALU_ADD: begin
        wide  = {1'b0, a_i} + {1'b0, b};
        res   = wide[DATA_WIDTH-1:0];
        carry = wide[DATA_WIDTH];
      end
      // The extra top bit of the widened difference is the borrow.
      ALU_SUB: begin
        wide  = {1'b0, a_i} - {1'b0, b};
        res   = wide[DATA_WIDTH-1:0];
        carry = wide[DATA_WIDTH];
      end
      ALU_INC: begin
        wide  = {1'b0, a_i} + ONE_W;
        res   = wide[DATA_WIDTH-1:0];
        carry = wide[DATA_WIDTH];
      end
      ALU_DEC: begin
        wide  = {1'b0, a_i} - ONE_W;
        res   = wide[DATA_WIDTH-1:0];
        carry = wide[DATA_WIDTH];
      end
      ALU_AND:  res = a_i & b;
      ALU_OR:   res = a_i | b;
      ALU_XOR:  res = a_i ^ b;
      ALU_NOT:  res = ~a_i;
      ALU_NAND: res = ~(a_i & b);
      ALU_NOR:  res = ~(a_i | b);
      ALU_XNOR: res = ~(a_i ^ b);
      ALU_SHL: begin
        res   = {a_i[DATA_WIDTH-2:0], 1'b0};
        carry = a_i[DATA_WIDTH-1];
      end
      ALU_SHR: begin
        res   = {1'b0, a_i[DATA_WIDTH-1:1]};
        carry = a_i[0];
      end
      ALU_ROL: res = {a_i[DATA_WIDTH-2:0], a_i[DATA_WIDTH-1]};
      ALU_ROR: res = {a_i[0], a_i[DATA_WIDTH-1:1]};
      ALU_PASS: begin
`ifdef ALU_MULT_EN
        res   = prod[DATA_WIDTH-1:0];
        carry = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
`else
        res   = b;
`endif
      end
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end

  // An illegal operand select still produces a pipeline entry, forced to zero.
  always_comb begin
    res_o         = res;
    flags_o.carry = carry;
    flags_o.err   = 1'b0;
    if (movi_i == MOVI_ILL) begin
      res_o         = '0;
      flags_o.carry = 1'b0;
      flags_o.err   = 1'b1;
    end
    flags_o.zero = (res_o == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: valid/ready input, PIPE_STAGES result registers, output backpressure.
// Build with ALU_MULT_EN defined to turn OP 15 into an unsigned multiply.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ACT,
  output logic                  ALU_RDY,
  input  logic [3:0]            OP,
  input  logic [1:0]            MOVI,
  input  logic [DATA_WIDTH-1:0] REG_A,
  input  logic [DATA_WIDTH-1:0] REG_B,
  input  logic [DATA_WIDTH-1:0] MEM,
  input  logic [DATA_WIDTH-1:0] IMM,
  input  logic                  OUT_RDY,
  output logic [DATA_WIDTH-1:0] EX_ALU,
  output logic                  EX_ALU_VLD,
  output logic                  EX_CARRY,
  output logic                  EX_ZERO,
  output logic                  EX_ERR
);

  if (DATA_WIDTH < ALU_DW_MIN || DATA_WIDTH > ALU_DW_MAX) begin : g_bad_dw
    $error("alu_pipe: DATA_WIDTH out of range");
  end
  if (PIPE_STAGES < ALU_PS_MIN || PIPE_STAGES > ALU_PS_MAX) begin : g_bad_ps
    $error("alu_pipe: PIPE_STAGES out of range");
  end

  localparam int LAST = PIPE_STAGES - 1;

  logic [DATA_WIDTH-1:0] calc_res;
  alu_flags_t            calc_flags;

  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]  res_q [PIPE_STAGES];
  alu_flags_t             flg_q [PIPE_STAGES];
  logic                   adv;

  alu_pipe_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_calc (
    .op_i   (alu_op_t'(OP)),
    .movi_i (alu_movi_t'(MOVI)),
    .a_i    (REG_A),
    .reg_b_i(REG_B),
    .mem_i  (MEM),
    .imm_i  (IMM),
    .res_o  (calc_res),
    .flags_o(calc_flags)
  );

  // The whole chain moves together; bubbles are held rather than squeezed out.
  assign adv     = !vld_q[LAST] || OUT_RDY;
  assign ALU_RDY = adv;

  always_comb begin
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = ACT;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      if (adv) begin
        if (ACT) begin
          res_q[0] <= calc_res;
          flg_q[0] <= calc_flags;
        end
        for (int i = 1; i < PIPE_STAGES; i++) begin
          if (vld_q[i-1]) begin
            res_q[i] <= res_q[i-1];
            flg_q[i] <= flg_q[i-1];
          end
        end
      end
    end
  end

  assign EX_ALU_VLD = vld_q[LAST];
  assign EX_ALU     = res_q[LAST];
  assign EX_CARRY   = flg_q[LAST].carry;
  assign EX_ZERO    = flg_q[LAST].zero;
  assign EX_ERR     = flg_q[LAST].err;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the single-stage ALU entity wrapped by the ALU verification DUT. It accepts one operation per cycle over a valid/ready handshake and selects operand B from REG_B, MEM or IMM. It delivers the result and flags after a fixed PIPE_STAGES latency, and supports output backpressure. It sits between the decode/register-read logic and the execute write-back stage.

Parameters:
DATA_WIDTH, 8, operand/result width in bits, range 4..64
PIPE_STAGES, 2, register stages from accept to output, range 1..4

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  asynchronous, active-low reset
ACT  in  1  input valid
ALU_RDY  out  1  input ready; transfer occurs when ACT && ALU_RDY
OP  in  4  operation code (alu_op_t)
MOVI  in  2  operand-B select: 00 REG_B, 01 MEM, 10 IMM, 11 illegal
REG_A  in  DATA_WIDTH  operand A
REG_B  in  DATA_WIDTH  operand B candidate
MEM  in  DATA_WIDTH  operand B candidate
IMM  in  DATA_WIDTH  operand B candidate
OUT_RDY  in  1  downstream ready
EX_ALU  out  DATA_WIDTH  result
EX_ALU_VLD  out  1  result valid; transfer when EX_ALU_VLD && OUT_RDY
EX_CARRY  out  1  carry/borrow flag
EX_ZERO  out  1  result == 0
EX_ERR  out  1  illegal MOVI

Behaviour:
- Reset (RST=0, async): all stage-valid bits cleared. EX_ALU, EX_CARRY, EX_ZERO, EX_ERR, EX_ALU_VLD = 0. ALU_RDY = 1 once RST is released. In-flight operations are discarded, including on reset mid-operation.
- Compute is combinational on accepted inputs. Result and flags enter stage 1 on accept, then shift one stage per advancing cycle. Latency is exactly PIPE_STAGES cycles with no stall.
- Global advance: adv = !EX_ALU_VLD || OUT_RDY. ALU_RDY = adv. On !adv all stages hold, including bubbles. Bubbles are not squeezed.
- Stage-1 valid loads ACT && adv when adv=1. Data registers load only when their incoming valid=1, which holds the old data on bubbles.
- Simultaneous output consumption and input accept in the same cycle is legal, giving full throughput of 1 op/cycle.
- Ops, with B = selected operand and width-truncated results:
  - 0 ADD A+B, carry = bit DATA_WIDTH
  - 1 SUB A-B, carry = borrow (A<B unsigned)
  - 2 INC A+1, carry on wrap all-ones->0
  - 3 DEC A-1, carry on wrap 0->all-ones
  - 4 AND, 5 OR, 6 XOR, 7 NOT A, 8 NAND, 9 NOR, 10 XNOR
  - 11 SHL A by 1, carry = old MSB
  - 12 SHR A by 1 logical, carry = old LSB
  - 13 ROL A, 14 ROR A
  - 15 PASS B
  - For ops 4..10 and 13..15, carry = 0.
- MOVI=11: result 0, EX_CARRY 0, EX_ZERO 1, EX_ERR 1. The operation is still accepted and counts in the pipeline.
- EX_ZERO is computed on the final truncated result.
- Outputs are stable while EX_ALU_VLD=1 and OUT_RDY=0.

Optional Feature:
ALU_MULT_EN
- Defined: OP 15 = MUL, result = low DATA_WIDTH bits of A*B unsigned. EX_CARRY = 1 iff the high half is non-zero. Latency is unchanged.
- Undefined: OP 15 = PASS B, and no multiplier is synthesised.

Decomposition:
- Package alu_pipe_pkg:
  - alu_op_t enum (4 bit)
  - alu_movi_t enum (2 bit)
  - alu_flags_t struct {carry, zero, err}
  - parameter range limits
- Sub-module alu_pipe_calc: purely combinational operand select, operation and flag generation. The top level holds the handshake and the PIPE_STAGES register chain.

Test Plan (DATA_WIDTH=8, PIPE_STAGES=2, OUT_RDY=1 unless stated):
- ADD, A=0xF0, REG_B=0x20, MOVI=00 -> EX_ALU_VLD after 2 cycles, EX_ALU=0x10, EX_CARRY=1, EX_ZERO=0.
- SUB via IMM, A=0x05, IMM=0x05, MOVI=10 -> EX_ALU=0x00, EX_ZERO=1, EX_CARRY=0. Same op with IMM=0x06 -> 0xFF, EX_CARRY=1.
- Back-to-back ops 0..15 on consecutive cycles (A=0x81, MEM=0x03, MOVI=01) -> 16 results on 16 consecutive cycles, e.g. SHL=0x02 carry 1, ROR=0xC0, PASS=0x03 (MUL=0x83 carry 1 with ALU_MULT_EN).
- Backpressure: 3 ops issued, OUT_RDY=0 for 4 cycles -> ALU_RDY=0 from the cycle EX_ALU_VLD rises, EX_ALU held stable. OUT_RDY=1 -> results drain in order with no loss or duplication.
- MOVI=11 with any OP -> EX_ERR=1, EX_ALU=0, EX_ZERO=1. The next legal op has EX_ERR=0.
- RST asserted with 2 ops in flight -> EX_ALU_VLD=0 and all outputs 0 immediately (asynchronously). After release no stale result appears and ALU_RDY=1.
